// File: rtl/dmem_responder.sv
// Data-memory responder: registered loads, byte-lane merged stores,
// sticky error flags and a committed-store counter.
//
// Ports:
//   CLK, rst      clock, synchronous active-high reset
//   RADDR, RWHBS  load byte address and size (00 byte, 01 half, 10 word)
//   WADDR, WData  store byte address and right-aligned store data
//   WWHBS, WE     store size and store request
//   ErrClr        clears both sticky error flags
//   RAMData       registered, zero-extended load data
//   ErrAlign      sticky misaligned / illegal-size flag
//   ErrRange      sticky out-of-range flag
//   WrCount       committed store count, wraps at 16 bits
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [31:0] RADDR,
  input  logic [1:0]  RWHBS,
  input  logic [31:0] WADDR,
  input  logic [31:0] WData,
  input  logic [1:0]  WWHBS,
  input  logic        WE,
  input  logic        ErrClr,
  output logic [31:0] RAMData,
  output logic        ErrAlign,
  output logic        ErrRange,
  output logic [15:0] WrCount
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  function automatic logic aligned(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic ok;
    unique case (sz)
      2'b00:   ok = 1'b1;
      2'b01:   ok = !off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] lane_mask(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic [31:0] m;
    unique case (sz)
      2'b00:   m = 32'h0000_00FF << {off, 3'b000};
      2'b01:   m = 32'h0000_FFFF << {off[1], 4'b0000};
      2'b10:   m = 32'hFFFF_FFFF;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_rep(
    input logic [1:0]  sz,
    input logic [31:0] d
  );
    logic [31:0] r;
    unique case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] r_off;
  logic [31:0] w_off;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx;
  logic r_inr;
  logic w_inr;
  logic r_al;
  logic w_al;
  logic w_ok;
  logic [31:0] w_mask;
  logic [31:0] merged;
  logic [31:0] r_word;
  logic [31:0] sh_b;
  logic [31:0] sh_h;
  logic [31:0] r_data;
  logic err_a;
  logic err_r;

  // Offsets below ADDR_BASE wrap to large values and fail the span test.
  assign r_off = RADDR - ADDR_BASE;
  assign w_off = WADDR - ADDR_BASE;
  assign r_inr = r_off < SPAN;
  assign w_inr = w_off < SPAN;
  assign r_idx = r_off[AW+1:2];
  assign w_idx = w_off[AW+1:2];
  assign r_al  = aligned(RWHBS, RADDR[1:0]);
  assign w_al  = aligned(WWHBS, WADDR[1:0]);
  assign w_ok  = WE && !rst && w_al && w_inr;

  assign w_mask = lane_mask(WWHBS, WADDR[1:0]);
  assign merged = (mem[w_idx] & ~w_mask)
                | (lane_rep(WWHBS, WData) & w_mask);

  // Write-first: a load of the word being stored sees the merged value.
  assign r_word = (w_ok && (w_idx == r_idx)) ? merged : mem[r_idx];
  assign sh_b   = r_word >> {RADDR[1:0], 3'b000};
  assign sh_h   = r_word >> {RADDR[1], 4'b0000};

  always_comb begin
    r_data = 32'h0;
    if (r_inr && r_al) begin
      unique case (RWHBS)
        2'b00:   r_data = {24'h0, sh_b[7:0]};
        2'b01:   r_data = {16'h0, sh_h[15:0]};
        default: r_data = r_word;
      endcase
    end
  end

  // A misaligned half/word load only zeroes the data; flags come from
  // illegal load sizes, out-of-range loads and bad stores.
  assign err_a = (WE && !w_al) || (RWHBS == 2'b11);
  assign err_r = (WE && !w_inr) || !r_inr;

  always_ff @(posedge CLK) begin
    if (w_ok) begin
      mem[w_idx] <= merged;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      RAMData  <= 32'h0;
      ErrAlign <= 1'b0;
      ErrRange <= 1'b0;
      WrCount  <= 16'h0;
    end else begin
      RAMData  <= r_data;
      ErrAlign <= err_a || (ErrAlign && !ErrClr);
      ErrRange <= err_r || (ErrRange && !ErrClr);
      if (w_ok) begin
        WrCount <= WrCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-level reference model checked every
// cycle, plus directed literal checks and randomized traffic.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0100;
  localparam int unsigned NB    = 4 * DEPTH;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] RADDR = BASE;
  logic [1:0]  RWHBS = 2'b10;
  logic [31:0] WADDR = BASE;
  logic [31:0] WData = 32'h0;
  logic [1:0]  WWHBS = 2'b10;
  logic        WE = 1'b0;
  logic        ErrClr = 1'b0;
  logic [31:0] RAMData;
  logic        ErrAlign;
  logic        ErrRange;
  logic [15:0] WrCount;

  int npass = 0;
  int ntot  = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)) dut (
    .CLK(CLK), .rst(rst),
    .RADDR(RADDR), .RWHBS(RWHBS),
    .WADDR(WADDR), .WData(WData), .WWHBS(WWHBS), .WE(WE),
    .ErrClr(ErrClr),
    .RAMData(RAMData), .ErrAlign(ErrAlign), .ErrRange(ErrRange),
    .WrCount(WrCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp,
                  $time);
  endtask

  // Reference model: memory as a byte array with known-bits.
  logic [7:0]  mb [NB];
  bit          kb [NB];
  logic [15:0] mcnt;
  bit          mea, mer, mdk;
  logic [31:0] mdata;

  function automatic bit alg(input logic [1:0] s, input logic [31:0] a);
    if (s == 2'd0) return 1;
    if (s == 2'd1) return a % 2 == 0;
    if (s == 2'd2) return a % 4 == 0;
    return 0;
  endfunction

  function automatic bit inr(input logic [31:0] a);
    longint x;
    x = longint'(a);
    return x >= longint'(BASE) && x < longint'(BASE) + longint'(NB);
  endfunction

  initial for (int i = 0; i < NB; i++) kb[i] = 0;

  always @(posedge CLK) begin
    bit wa, wi, ra, ri;
    int n;
    if (rst) begin
      mdata = 0; mdk = 1; mea = 0; mer = 0; mcnt = 0;
    end else begin
      wa = alg(WWHBS, WADDR); wi = inr(WADDR);
      ra = alg(RWHBS, RADDR); ri = inr(RADDR);
      if (WE && wa && wi) begin
        n = 1 << WWHBS;
        for (int i = 0; i < n; i++) begin
          mb[int'(WADDR - BASE) + i] = WData[8*i +: 8];
          kb[int'(WADDR - BASE) + i] = 1;
        end
        mcnt = mcnt + 16'd1;
      end
      mea = (WE && !wa) || RWHBS == 2'd3 || (mea && !ErrClr);
      mer = (WE && !wi) || !ri || (mer && !ErrClr);
      mdata = 0; mdk = 1;
      if (ra && ri) begin
        n = 1 << RWHBS;
        for (int i = 0; i < n; i++) begin
          mdata[8*i +: 8] = mb[int'(RADDR - BASE) + i];
          if (!kb[int'(RADDR - BASE) + i]) mdk = 0;
        end
      end
    end
    #1;
    if (mdk) chk("model_rdata", RAMData, mdata);
    chk("model_erralign", {31'b0, ErrAlign}, {31'b0, mea});
    chk("model_errrange", {31'b0, ErrRange}, {31'b0, mer});
    chk("model_wrcount", {16'b0, WrCount}, {16'b0, mcnt});
  end

  task automatic cyc(input logic r, input logic we,
                     input logic [31:0] wa, input logic [31:0] wd,
                     input logic [1:0] ws, input logic [31:0] ra,
                     input logic [1:0] rs, input logic clr);
    rst = r; WE = we; WADDR = wa; WData = wd; WWHBS = ws;
    RADDR = ra; RWHBS = rs; ErrClr = clr;
    @(posedge CLK);
    #2;
  endtask

  task automatic ld(input logic [31:0] ra, input logic [1:0] rs);
    cyc(0, 0, BASE, 0, 2, ra, rs, 0);
  endtask

  task automatic st(input logic [31:0] wa, input logic [31:0] wd,
                    input logic [1:0] ws);
    cyc(0, 1, wa, wd, ws, BASE, 2, 0);
  endtask

  logic [31:0] ra_r, wa_r;
  logic [1:0]  rs_r, ws_r;
  logic [15:0] c0;

  initial begin
    // reset and word round-trip
    cyc(1, 0, BASE, 0, 2, BASE + 8, 2, 0);
    cyc(1, 0, BASE, 0, 2, BASE + 8, 2, 0);
    chk("rst_rdata", RAMData, 32'h0);
    chk("rst_flags", {30'b0, ErrAlign, ErrRange}, 32'h0);
    chk("rst_count", {16'b0, WrCount}, 32'h0);
    cyc(0, 1, BASE + 8, 32'h0C84_8493, 2, BASE + 8, 2, 0);
    ld(BASE + 8, 2);
    chk("rt_word", RAMData, 32'h0C84_8493);
    chk("rt_count", {16'b0, WrCount}, 32'd1);

    for (int i = 0; i < int'(DEPTH); i++) st(BASE + 32'(4 * i), 0, 2);

    // byte and half merge
    st(BASE, 32'h1122_3344, 2);
    st(BASE + 1, 32'hFFFF_FFAA, 0);
    ld(BASE, 2);
    chk("merge_byte", RAMData, 32'h1122_AA44);
    st(BASE + 2, 32'h1234_BEEF, 1);
    ld(BASE, 2);
    chk("merge_half", RAMData, 32'hBEEF_AA44);
    ld(BASE + 2, 1);
    chk("load_half", RAMData, 32'h0000_BEEF);
    ld(BASE + 3, 0);
    chk("load_byte", RAMData, 32'h0000_00BE);

    // same-cycle collision
    cyc(0, 1, BASE + 6, 32'h0000_005A, 0, BASE + 4, 2, 0);
    chk("collide", RAMData, 32'h005A_0000);

    // misaligned and illegal
    c0 = WrCount;
    cyc(0, 1, BASE + 1, 32'h0000_FFFF, 1, BASE, 2, 0);
    chk("mis_st_flag", {31'b0, ErrAlign}, 32'd1);
    chk("mis_st_count", {16'b0, WrCount}, {16'b0, mcnt});
    ld(BASE, 2);
    chk("mis_st_nochg", RAMData, 32'hBEEF_AA44);
    cyc(0, 0, BASE, 0, 2, BASE + 2, 2, 1);
    chk("mis_ld_data", RAMData, 32'h0);
    chk("mis_ld_noflag", {31'b0, ErrAlign}, 32'd0);
    ld(BASE, 3);
    chk("illegal_flag", {31'b0, ErrAlign}, 32'd1);
    cyc(0, 0, BASE, 0, 2, BASE, 2, 1);
    chk("clr_align", {31'b0, ErrAlign}, 32'd0);

    // range boundary
    st(BASE + NB - 4, 32'hCAFE_F00D, 2);
    chk("top_ok", {16'b0, WrCount}, {16'b0, c0 + 16'd1});
    ld(BASE + NB - 4, 2);
    chk("top_data", RAMData, 32'hCAFE_F00D);
    st(BASE + NB, 32'h1, 2);
    chk("oor_flag", {31'b0, ErrRange}, 32'd1);
    chk("oor_count", {16'b0, WrCount}, {16'b0, c0 + 16'd1});
    cyc(0, 0, BASE, 0, 2, BASE - 4, 2, 1);
    chk("oor_clr_hold", {31'b0, ErrRange}, 32'd1);
    chk("oor_ld_data", RAMData, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ws_r = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rs_r = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      wa_r = BASE + $urandom_range(0, NB - 1);
      ra_r = BASE + $urandom_range(0, NB - 1);
      if ($urandom_range(0, 15) == 0) wa_r = BASE + NB + $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) ra_r = BASE - 1 - $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) ra_r = wa_r;
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
          wa_r, $urandom, ws_r, ra_r, rs_r, ($urandom_range(0, 7) == 0));
    end

    // counter wrap, then reset during a store
    cyc(1, 0, BASE, 0, 2, BASE, 2, 0);
    st(BASE + 12, 32'h1234_5678, 2);
    for (int i = 1; i < 65536; i++) st(BASE + 16, 32'(i), 2);
    chk("wrap_count", {16'b0, WrCount}, 32'h0);
    cyc(1, 1, BASE + 12, 32'hDEAD_BEEF, 2, BASE + 12, 2, 0);
    ld(BASE + 12, 2);
    chk("rst_drop_data", RAMData, 32'h1234_5678);
    chk("rst_drop_count", {16'b0, WrCount}, 32'h0);

    @(posedge CLK);
    #3;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
